xalu_md_unit: RTL

//  Multi-cycle multiply/divide unit with HI/LO registers, driven by the E-stage XALU_OP code.

---
 rtl/xalu_md_unit_if.sv | 28 ++
 rtl/xalu_md_unit.sv | 132 +++++++++++++
 2 files changed

// File: rtl/xalu_md_unit_if.sv
// Operation and HI/LO bus between the E stage and the multiply/divide unit.
// The pipeline side drives the master modport; the unit sits on the slave modport.
interface xalu_md_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/xalu_md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers. The result is computed at
// issue and held back for the class latency, so only the issue/commit timing is visible.
module xalu_md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    xalu_md_unit_if.slave md
);
    localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

    localparam logic [3:0] OP_MULT  = 4'd2;
    localparam logic [3:0] OP_MULTU = 4'd3;
    localparam logic [3:0] OP_DIV   = 4'd4;
    localparam logic [3:0] OP_DIVU  = 4'd5;
    localparam logic [3:0] OP_MADD  = 4'd6;
    localparam logic [3:0] OP_MADDU = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;
    localparam logic [3:0] OP_MSUBU = 4'd9;

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   res_q;
    logic [WIDTH-1:0]     hi_q, lo_q;
    logic                 done_q;
    logic                 accept, commit;

    logic                 op_valid, is_div;
    logic [2*WIDTH-1:0]   prod_s, prod_u, hilo, result;
    logic [WIDTH-1:0]     a_mag, b_mag, q_mag, r_mag, q_u, r_u;

    assign op_valid = (md.op >= OP_MULT) && (md.op <= OP_MSUBU);
    assign is_div   = (md.op == OP_DIV) || (md.op == OP_DIVU);

    // Result for the op being offered this cycle; HI/LO are stable in IDLE, so the
    // accumulate forms can use the live registers as their snapshot.
    always_comb begin
        prod_s = {{WIDTH{md.a[WIDTH-1]}}, md.a} * {{WIDTH{md.b[WIDTH-1]}}, md.b};
        prod_u = {{WIDTH{1'b0}}, md.a} * {{WIDTH{1'b0}}, md.b};
        hilo   = {hi_q, lo_q};
        a_mag  = md.a[WIDTH-1] ? -md.a : md.a;
        b_mag  = md.b[WIDTH-1] ? -md.b : md.b;
        q_mag  = (b_mag == '0) ? '0 : a_mag / b_mag;
        r_mag  = (b_mag == '0) ? '0 : a_mag % b_mag;
        q_u    = (md.b == '0) ? '0 : md.a / md.b;
        r_u    = (md.b == '0) ? '0 : md.a % md.b;
        result = prod_u;
        case (md.op)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_MADD:  result = hilo + prod_s;
            OP_MADDU: result = hilo + prod_u;
            OP_MSUB:  result = hilo - prod_s;
            OP_MSUBU: result = hilo - prod_u;
            OP_DIV:   result = {(md.a[WIDTH-1] ? -r_mag : r_mag),
                                ((md.a[WIDTH-1] ^ md.b[WIDTH-1]) ? -q_mag : q_mag)};
            OP_DIVU:  result = {r_u, q_u};
            default:  result = prod_u;
        endcase
        if (is_div && (md.b == '0)) begin
            result = {md.a, {WIDTH{1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush outranks the final count so a cancelled op never commits.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (md.start && op_valid && !md.flush) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (md.flush) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            res_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= commit;
            if (accept) begin
                res_q <= result;
                cnt_q <= is_div ? DIV_LOAD : MULT_LOAD;
            end else if ((state_q == RUN) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (commit) begin
                {hi_q, lo_q} <= res_q;
            end else if ((state_q == IDLE) && !accept) begin
                if (md.hi_we) hi_q <= md.wdata;
                if (md.lo_we) lo_q <= md.wdata;
            end
        end
    end

    assign md.busy = (state_q == RUN);
    assign md.done = done_q;
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;
endmodule
